// File: rtl/imem_responder.sv
// imem_responder: instruction-memory fetch responder.
// Accepts one fetch per cycle (valid/ready), reads a word-addressed store through a
// fixed LATENCY-stage pipeline and buffers responses in a fall-through FIFO.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready request handshake; req_addr byte address of the fetch
//   rsp_valid/ready response handshake; rsp_instr/rsp_addr/rsp_err response payload
//   prog_we/addr/data side write port into the instruction store
module imem_responder #(
   parameter int unsigned MEM_WORDS  = 1024,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_instr,
   output logic [31:0] rsp_addr,
   output logic        rsp_err,
   input  logic        prog_we,
   input  logic [31:0] prog_addr,
   input  logic [31:0] prog_data
);

   localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   // Instruction store; deliberately not reset.
   logic [31:0] mem_q [MEM_WORDS];

   // Read pipeline stages: stage 0 holds the registered store read.
   logic [LATENCY-1:0] pv_q;
   logic [31:0]        pa_q [LATENCY];
   logic [LATENCY-1:0] pe_q;
   logic [31:0]        pd_q [LATENCY];

   // Response FIFO.
   logic [31:0]   fi_q [FIFO_DEPTH];
   logic [31:0]   fa_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fe_q;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Credits: in-flight pipeline entries plus FIFO occupancy.
   logic [CW-1:0] out_q, out_d;

   logic          accept_c;
   logic          pop_c;
   logic          push_c;
   logic          req_err_c;
   logic [AW-1:0] req_widx_c;
   logic          prog_ok_c;
   logic [AW-1:0] prog_widx_c;
   logic          unused_c;

   assign unused_c = ^prog_addr[1:0];

   assign req_err_c   = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(MEM_WORDS));
   assign req_widx_c  = req_addr[AW+1:2];
   assign prog_ok_c   = prog_addr[31:2] < 30'(MEM_WORDS);
   assign prog_widx_c = prog_addr[AW+1:2];

   // Ready depends only on registered credit state (and reset), never on req_valid.
   assign req_ready = (out_q < CW'(FIFO_DEPTH)) & ~rst;
   assign accept_c  = req_valid & req_ready;

   assign rsp_valid = (cnt_q != '0);
   assign rsp_instr = fi_q[rd_ptr_q];
   assign rsp_addr  = fa_q[rd_ptr_q];
   assign rsp_err   = fe_q[rd_ptr_q];

   assign pop_c  = rsp_valid & rsp_ready;
   assign push_c = pv_q[LATENCY-1];

   // Next-state for FIFO pointers and credit counter.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      if (push_c) wr_ptr_d = PW'(wr_ptr_q + PW'(1));
      if (pop_c)  rd_ptr_d = PW'(rd_ptr_q + PW'(1));
      case ({push_c, pop_c})
         2'b10:   cnt_d = CW'(cnt_q + CW'(1));
         2'b01:   cnt_d = CW'(cnt_q - CW'(1));
         default: cnt_d = cnt_q;
      endcase
      case ({accept_c, pop_c})
         2'b10:   out_d = CW'(out_q + CW'(1));
         2'b01:   out_d = CW'(out_q - CW'(1));
         default: out_d = out_q;
      endcase
   end

   // Store write port; a same-edge read in the pipeline still sees the old word.
   always_ff @(posedge clk) begin
      if (prog_we && prog_ok_c) mem_q[prog_widx_c] <= prog_data;
   end

   // Read pipeline: always advances, no internal back-pressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         pv_q <= '0;
         pe_q <= '0;
         for (int k = 0; k < int'(LATENCY); k++) begin
            pa_q[k] <= '0;
            pd_q[k] <= '0;
         end
      end else begin
         pv_q[0] <= accept_c;
         if (accept_c) begin
            pa_q[0] <= req_addr;
            pe_q[0] <= req_err_c;
            pd_q[0] <= req_err_c ? NOP_INSTR : mem_q[req_widx_c];
         end
         for (int k = 1; k < int'(LATENCY); k++) begin
            pv_q[k] <= pv_q[k-1];
            pa_q[k] <= pa_q[k-1];
            pe_q[k] <= pe_q[k-1];
            pd_q[k] <= pd_q[k-1];
         end
      end
   end

   // Response FIFO and credit state; the last stage pushes unconditionally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         fe_q     <= '0;
         for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
            fi_q[k] <= '0;
            fa_q[k] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         if (push_c) begin
            fi_q[wr_ptr_q] <= pd_q[LATENCY-1];
            fa_q[wr_ptr_q] <= pa_q[LATENCY-1];
            fe_q[wr_ptr_q] <= pe_q[LATENCY-1];
         end
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: expected responses are queued on accept and
// checked by a monitor whenever the DUT presents a response.
module tb_imem_responder;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic [31:0] rsp_addr;
   logic        rsp_err;
   logic        prog_we;
   logic [31:0] prog_addr;
   logic [31:0] prog_data;

   int n_cmp = 0;
   int n_bad = 0;
   int n_acc = 0;
   int n_pop = 0;
   logic [31:0] last_instr = '0;

   exp_t        sb[$];
   logic [31:0] mdl [1024];

   logic        stall_q = 1'b0;
   logic [31:0] prev_instr, prev_addr;
   logic        prev_err;

   imem_responder dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_instr (rsp_instr),
      .rsp_addr  (rsp_addr),
      .rsp_err   (rsp_err),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk_exp(input logic [31:0] a);
      exp_t e;
      e.addr  = a;
      e.err   = (a[1:0] != 2'b00) || (a[31:2] >= 30'd1024);
      e.instr = e.err ? 32'h0000_0013 : mdl[a[11:2]];
      return e;
   endfunction

   // Monitor and acceptance observer, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_instr", rsp_instr, prev_instr);
            chk("stall_addr",  rsp_addr,  prev_addr);
            chk("stall_err",   32'(rsp_err), 32'(prev_err));
         end
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
               chk("rsp_instr", rsp_instr, sb[0].instr);
               chk("rsp_addr",  rsp_addr,  sb[0].addr);
               chk("rsp_err",   32'(rsp_err), 32'(sb[0].err));
               if (rsp_ready) begin
                  void'(sb.pop_front());
                  n_pop++;
                  last_instr = rsp_instr;
               end
            end
         end
         stall_q    = rsp_valid & ~rsp_ready;
         prev_instr = rsp_instr;
         prev_addr  = rsp_addr;
         prev_err   = rsp_err;
         // Expectation uses the store as it is before this edge's write.
         if (req_valid && req_ready) begin
            sb.push_back(mk_exp(req_addr));
            n_acc++;
         end
         if (prog_we && (prog_addr[31:2] < 30'd1024)) mdl[prog_addr[11:2]] = prog_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input int word, input logic [31:0] data);
      prog_we   = 1'b1;
      prog_addr = 32'(word) << 2;
      prog_data = data;
      step();
      prog_we = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || rsp_valid) && n < 200) begin
         step();
         n++;
      end
      chk(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int a0;
      logic [31:0] exp_seq [4];
      exp_seq[0] = 32'h11; exp_seq[1] = 32'h22; exp_seq[2] = 32'h33; exp_seq[3] = 32'h44;
      for (int i = 0; i < 1024; i++) mdl[i] = '0;
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      repeat (3) step();

      // Reset state.
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_instr", rsp_instr, 32'd0);
      chk("reset_rsp_addr",  rsp_addr,  32'd0);
      chk("reset_rsp_err",   32'(rsp_err), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_reset_ready", 32'(req_ready), 32'd1);

      // Program words 0..7.
      for (int i = 0; i < 8; i++) prog(i, 32'((i + 1) * 32'h11));

      // Back-to-back fetches; latency and one response per cycle.
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h0;
      step();
      req_addr = 32'h4;
      chk("lat_edge1_valid", 32'(rsp_valid), 32'd0);
      step();
      req_addr = 32'h8;
      chk("lat_edge2_valid", 32'(rsp_valid), 32'd0);
      step();
      req_addr = 32'hC;
      for (int i = 0; i < 4; i++) begin
         chk("stream_valid", 32'(rsp_valid), 32'd1);
         chk("stream_instr", rsp_instr, exp_seq[i]);
         chk("stream_ready", 32'(req_ready), 32'd1);
         step();
         req_valid = 1'b0;
      end
      drain("drain_stream");

      // Fill with rsp_ready low: exactly FIFO_DEPTH accepted.
      rsp_ready = 1'b0;
      a0 = n_acc;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1;
         req_addr  = 32'(i % 4) << 2;
         step();
      end
      req_valid = 1'b0;
      chk("full_accepts", 32'(n_acc - a0), 32'd4);
      chk("full_ready", 32'(req_ready), 32'd0);
      chk("full_head", rsp_instr, 32'h11);
      rsp_ready = 1'b1;
      step();
      chk("ready_after_pop", 32'(req_ready), 32'd1);
      drain("drain_full");

      // Error responses.
      req_valid = 1'b1; req_addr = 32'h2;
      step();
      req_addr = 32'h1000;
      step();
      req_valid = 1'b0;
      drain("drain_err");
      chk("err_last_instr", last_instr, 32'h13);

      // Same-cycle write and read of word 2.
      req_valid = 1'b1; req_addr = 32'h8;
      prog_we = 1'b1; prog_addr = 32'h8; prog_data = 32'hDEAD;
      step();
      req_valid = 1'b0; prog_we = 1'b0;
      drain("drain_raw1");
      chk("raw_old_word", last_instr, 32'h33);
      req_valid = 1'b1; req_addr = 32'h8;
      step();
      req_valid = 1'b0;
      drain("drain_raw2");
      chk("raw_new_word", last_instr, 32'hDEAD);

      // Reset with three requests outstanding.
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_addr = 32'(i) << 2;
         step();
      end
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      step();
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("rst_release_ready", 32'(req_ready), 32'd1);
      rsp_ready = 1'b1;
      a0 = n_pop;
      repeat (8) step();
      chk("rst_no_stale_rsp", 32'(n_pop - a0), 32'd0);
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_addr = 32'(i) << 2;
         step();
      end
      req_valid = 1'b0;
      drain("drain_after_rst");
      chk("store_kept", last_instr, 32'h44);

      // Random valid/ready stalls against the scoreboard.
      for (int c = 0; c < 10000; c++) begin
         int r;
         r = int'($urandom_range(0, 9));
         req_valid = 1'($urandom_range(0, 1));
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (r < 8)       req_addr = 32'(r) << 2;
         else if (r == 8) req_addr = 32'h21;
         else             req_addr = 32'h1000;
         prog_we   = ($urandom_range(0, 7) == 0);
         prog_addr = 32'($urandom_range(0, 7)) << 2;
         prog_data = $urandom;
         step();
      end
      req_valid = 1'b0; prog_we = 1'b0; rsp_ready = 1'b1;
      drain("drain_random");
      chk("accept_pop_balance", 32'(n_acc - n_pop), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
